button_debounce: RTL

Conditions the raw push-button input before it reaches the calculator datapath and the display stage. Synchronises the asynchronous pad signal and filters contact bounce with a counter-based state machine. Produces a clean level, single-cycle press/release pulses and a wrap-around press counter, all in the clk_g domain. Sits between the board pin and both calculator_hex and calculator_display, which consume btn_level or press_pulse instead of the raw pin.

---
 rtl/button_debounce_if.sv | 36 +++
 rtl/button_debounce.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/button_debounce_if.sv
// -----------------------------------------------------------------------------
// button_debounce_if
// Groups the push-button signals exchanged between the board-side source and
// the debouncer.
//   button_in     : raw pad level, active-high when pressed (source -> debouncer)
//   btn_level     : debounced level (debouncer -> consumers)
//   press_pulse   : one-cycle strobe per accepted press / repeat
//   release_pulse : one-cycle strobe per accepted release
//   press_cnt     : 8-bit wrap-around count of press_pulse strobes
// Modports:
//   master : drives button_in, observes the conditioned outputs
//   slave  : the debouncer itself
// -----------------------------------------------------------------------------
interface button_debounce_if;
  logic       button_in;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [7:0] press_cnt;

  modport master (
    output button_in,
    input  btn_level,
    input  press_pulse,
    input  release_pulse,
    input  press_cnt
  );

  modport slave (
    input  button_in,
    output btn_level,
    output press_pulse,
    output release_pulse,
    output press_cnt
  );
endinterface

// File: rtl/button_debounce.sv
// -----------------------------------------------------------------------------
// button_debounce
// Synchronises the asynchronous push-button pad and removes contact bounce
// with a counter-based FSM (IDLE -> PRESS_CHK -> HELD -> RELEASE_CHK).
// Produces a clean level, one-cycle press/release strobes and an 8-bit
// wrap-around press counter, all registered in the clk domain.
//
// Ports:
//   clk   : system clock
//   rst   : asynchronous, active-low reset
//   btn   : button_debounce_if.slave (button_in in; btn_level, press_pulse,
//           release_pulse, press_cnt out)
//
// Optional feature macro: AUTO_REPEAT_EN
//   When defined, holding the button emits a press_pulse after REPEAT_DELAY
//   cycles in HELD and then every REPEAT_PERIOD cycles. When undefined the
//   repeat logic is not built and every press yields exactly one pulse.
// -----------------------------------------------------------------------------
module button_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000
) (
  input  logic             clk,
  input  logic             rst,
  button_debounce_if.slave btn
);

  localparam logic [1:0] ST_IDLE        = 2'd0;
  localparam logic [1:0] ST_PRESS_CHK   = 2'd1;
  localparam logic [1:0] ST_HELD        = 2'd2;
  localparam logic [1:0] ST_RELEASE_CHK = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [7:0]       press_cnt_q, press_cnt_d;

`ifdef AUTO_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned REP_W   = (REP_MAX > 32'd1) ? $clog2(REP_MAX) : 1;
  localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 32'd1);
  localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 32'd1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  // Set once the first (long) repeat delay has elapsed; later repeats use the period.
  logic             rep_armed_q, rep_armed_d;
  logic [REP_W-1:0] rep_target_s;

  assign rep_target_s = rep_armed_q ? REP_PERIOD_LAST : REP_DELAY_LAST;
`else
  // Repeat timing parameters have no effect without the repeat feature.
  logic unused_repeat_cfg_s;
  assign unused_repeat_cfg_s = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Two-flop synchroniser next-state; the FSM only ever looks at sync2.
  always_comb begin
    sync1_d = btn.button_in;
    sync2_d = sync1_q;
  end

  // Debounce FSM, counters and output strobes next-state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    level_d     = level_q;
    press_d     = 1'b0;
    release_d   = 1'b0;
    press_cnt_d = press_cnt_q;
`ifdef AUTO_REPEAT_EN
    // Anything other than a continued hold in HELD clears the repeat timer.
    rep_cnt_d   = '0;
    rep_armed_d = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        level_d = 1'b0;
        cnt_d   = '0;
        if (sync2_q) begin
          state_d = ST_PRESS_CHK;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_PRESS_CHK: begin
        if (!sync2_q) begin
          // Bounce: restart from scratch rather than accumulate.
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_HELD;
          cnt_d       = '0;
          level_d     = 1'b1;
          press_d     = 1'b1;
          press_cnt_d = press_cnt_q + 8'd1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_HELD: begin
        if (!sync2_q) begin
          state_d = ST_RELEASE_CHK;
          cnt_d   = '0;
        end else begin
          state_d = ST_HELD;
`ifdef AUTO_REPEAT_EN
          if (rep_cnt_q == rep_target_s) begin
            press_d     = 1'b1;
            press_cnt_d = press_cnt_q + 8'd1;
            rep_cnt_d   = '0;
            rep_armed_d = 1'b1;
          end else begin
            rep_cnt_d   = rep_cnt_q + REP_W'(1);
            rep_armed_d = rep_armed_q;
          end
`endif
        end
      end

      ST_RELEASE_CHK: begin
        if (sync2_q) begin
          // Release glitch: back to HELD, level never dropped.
          state_d = ST_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q     <= 1'b0;
      sync2_q     <= 1'b0;
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      press_cnt_q <= 8'd0;
    end else begin
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      press_q     <= press_d;
      release_q   <= release_d;
      press_cnt_q <= press_cnt_d;
    end
  end

`ifdef AUTO_REPEAT_EN
  // Auto-repeat timer registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_cnt_q   <= '0;
      rep_armed_q <= 1'b0;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_armed_q <= rep_armed_d;
    end
  end
`endif

  assign btn.btn_level     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.press_cnt     = press_cnt_q;

endmodule
